// File: rtl/mem_block_ctrl_if.sv
// mem_block_ctrl_if: request/response bundle between the cache controller
// (master) and the block-transfer memory controller (slave).
interface mem_block_ctrl_if #(
  parameter int BLOCK_SIZE = 4,
  parameter int BADDR_BITS = 6
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [BADDR_BITS-1:0]     req_baddr;
  logic [32*BLOCK_SIZE-1:0]  req_wdata;
  logic                      resp_valid;
  logic [32*BLOCK_SIZE-1:0]  resp_rdata;
  logic                      busy;
  logic [15:0]               rd_count;
  logic [15:0]               wr_count;

  modport master (
    output req_valid, req_write, req_baddr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy, rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_write, req_baddr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy, rd_count, wr_count
  );
endinterface

// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl: word-addressable main-memory model with a whole-line
// fill/writeback engine. One request at a time: accept, wait LATENCY cycles,
// move one word per cycle, then pulse resp_valid for one cycle.
// Optional transfer statistics: define MEM_BLOCK_CTRL_STATS_EN.
module mem_block_ctrl #(
  parameter int BLOCK_SIZE = 4,
  parameter int MEM_WORDS  = 256,
  parameter int LATENCY    = 3
) (
  input logic             clk,
  input logic             reset,
  mem_block_ctrl_if.slave bus
);
  localparam int ADDR_BITS  = $clog2(MEM_WORDS);
  localparam int BLOCK_BITS = $clog2(BLOCK_SIZE);
  localparam int BADDR_BITS = ADDR_BITS - BLOCK_BITS;
  localparam int CNT_BITS   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                 state;
  logic [CNT_BITS-1:0]        wcnt;
  logic [BLOCK_BITS-1:0]      beat;
  logic                       write_q;
  logic [BADDR_BITS-1:0]      baddr_q;
  logic [BLOCK_SIZE-1:0][31:0] wdata_q;
  logic [BLOCK_SIZE-1:0][31:0] rdata_q;
  logic [31:0]                mem [MEM_WORDS];
  logic [ADDR_BITS-1:0]       addr;

  // beat only indexes within the line, so it never carries into baddr_q
  assign addr = {baddr_q, beat};

  // Transfer sequencer; request fields are captured only at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      beat    <= '0;
      write_q <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            baddr_q <= bus.req_baddr;
            wdata_q <= bus.req_wdata;
            beat    <= '0;
            if (LATENCY > 0) begin
              state <= S_WAIT;
              wcnt  <= CNT_BITS'(LATENCY - 1);
            end else begin
              state <= S_BURST;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_BURST;
          else            wcnt  <= wcnt - 1'b1;
        end
        S_BURST: begin
          beat <= beat + 1'b1;
          if (beat == BLOCK_BITS'(BLOCK_SIZE - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory array: identity contents on reset (drops any partial writeback)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'(i);
    end else if (state == S_BURST && write_q) begin
      mem[addr] <= wdata_q[beat];
    end
  end

  // Fill line register; only read bursts touch it, so it holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  rdata_q       <= '0;
    else if (state == S_BURST && !write_q)      rdata_q[beat] <= mem[addr];
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_rdata = rdata_q;

`ifdef MEM_BLOCK_CTRL_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Completed-transfer counters, bumped on the response cycle, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state == S_DONE) begin
      if (!write_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if ( write_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`else
  assign bus.rd_count = 16'd0;
  assign bus.wr_count = 16'd0;
`endif
endmodule

// File: tb/tb_mem_block_ctrl.sv
// tb_mem_block_ctrl: directed checks of mem_block_ctrl (LATENCY=3 and
// LATENCY=0 instances) with hand-computed expected values.
module tb_mem_block_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_block_ctrl_if #(.BLOCK_SIZE(4), .BADDR_BITS(6)) bus  ();
  mem_block_ctrl_if #(.BLOCK_SIZE(4), .BADDR_BITS(6)) bus0 ();

  mem_block_ctrl #(.BLOCK_SIZE(4), .MEM_WORDS(256), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  mem_block_ctrl #(.BLOCK_SIZE(4), .MEM_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // line whose word k holds b+k
  function automatic logic [127:0] seq4(input int b);
    return {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transfer on the LATENCY=3 instance; cycle 0 = accept cycle
  task automatic do_req(input logic wr, input logic [5:0] ba, input logic [127:0] wd,
                        input logic [127:0] exp_rd, input string tag);
    chk({tag, " ready c0"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_baddr = ba;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_baddr = ~ba;
    bus.req_wdata = ~wd;
    chk({tag, " busy c1"}, bus.busy, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("%s resp_valid c%0d", tag, c), bus.resp_valid, (c == 8));
      chk($sformatf("%s ready c%0d", tag, c), bus.req_ready, (c == 9));
      if (c == 8) chk({tag, " rdata"}, bus.resp_rdata, exp_rd);
      if (c < 9) step();
    end
  endtask

  logic [127:0] wa, wx, wy, w1, w2;
  int acc[$];
  logic rdy_b, vld_b;

  initial begin
    wa = {32'hD, 32'hC, 32'hB, 32'hA};
    wx = {32'h44, 32'h33, 32'h22, 32'h11};
    wy = {32'hFF, 32'hEE, 32'hDD, 32'hCC};
    w1 = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    w2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_baddr  = '0; bus.req_wdata  = '0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_baddr = '0; bus0.req_wdata = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // reset state
    chk("rst ready", bus.req_ready, 1'b1);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst resp_valid", bus.resp_valid, 1'b0);
    chk("rst rdata", bus.resp_rdata, '0);
    chk("rst rd_count", bus.rd_count, 16'd0);
    chk("rst wr_count", bus.wr_count, 16'd0);

    // fill, writeback, read-after-write, neighbouring block
    do_req(1'b0, 6'd5, '0, seq4(20), "rd5");
    do_req(1'b1, 6'd5, wa, seq4(20), "wr5");
    do_req(1'b0, 6'd5, '0, wa, "rd5b");
    do_req(1'b0, 6'd6, '0, seq4(24), "rd6");

    // requests held valid back-to-back: read 7, write 7 <- wx, read 7
    for (int c = 0; c < 30; c++) begin
      case (c)
        0:  begin bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_baddr = 6'd7; end
        1:  begin bus.req_write = 1'b1; bus.req_baddr = 6'd9; bus.req_wdata = '1; end
        5:  begin bus.req_baddr = 6'd7; bus.req_wdata = wx; end
        10: begin bus.req_write = 1'b0; bus.req_baddr = 6'd7; end
        12: bus.req_baddr = 6'd3;
        16: bus.req_baddr = 6'd7;
        19: bus.req_valid = 1'b0;
        default: ;
      endcase
      chk($sformatf("b2b resp_valid c%0d", c), bus.resp_valid, (c == 8 || c == 17 || c == 26));
      if (c == 8)  chk("b2b rdata c8", bus.resp_rdata, seq4(28));
      if (c == 17) chk("b2b rdata hold c17", bus.resp_rdata, seq4(28));
      if (c == 26) chk("b2b rdata c26", bus.resp_rdata, wx);
      rdy_b = bus.req_ready;
      vld_b = bus.req_valid;
      step();
      if (rdy_b && vld_b) acc.push_back(c);
    end
    chk("b2b accept count", 128'(acc.size()), 128'd3);
    if (acc.size() == 3) begin
      chk("b2b accept 0", 128'(acc[0]), 128'd0);
      chk("b2b accept 1", 128'(acc[1]), 128'd9);
      chk("b2b accept 2", 128'(acc[2]), 128'd18);
    end

    // reset in the middle of a writeback to block 2
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_baddr = 6'd2; bus.req_wdata = wy;
    step();
    bus.req_valid = 1'b0;
    step(); step(); step();
    chk("midrst busy before", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst ready", bus.req_ready, 1'b1);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst resp_valid", bus.resp_valid, 1'b0);
    chk("midrst rdata", bus.resp_rdata, '0);
    step();
    reset = 1'b0;
    step();
    do_req(1'b0, 6'd2, '0, seq4(8), "rd2 post-rst");
    do_req(1'b0, 6'd5, '0, seq4(20), "rd5 reinit");

    // stats: 3 reads + 2 writes since reset
    do_req(1'b1, 6'd1, w1, seq4(20), "wr1a");
    do_req(1'b1, 6'd1, w2, seq4(20), "wr1b");
    do_req(1'b0, 6'd1, '0, w2, "rd1");
`ifdef MEM_BLOCK_CTRL_STATS_EN
    chk("rd_count", bus.rd_count, 16'd3);
    chk("wr_count", bus.wr_count, 16'd2);
`else
    chk("rd_count", bus.rd_count, 16'd0);
    chk("wr_count", bus.wr_count, 16'd0);
`endif

    // LATENCY=0 instance: read block 0, response at accept+5
    chk("lat0 ready c0", bus0.req_ready, 1'b1);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_baddr = 6'd0;
    step();
    bus0.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("lat0 resp_valid c%0d", c), bus0.resp_valid, (c == 5));
      chk($sformatf("lat0 ready c%0d", c), bus0.req_ready, (c == 6));
      if (c == 5) chk("lat0 rdata", bus0.resp_rdata, seq4(0));
      if (c < 6) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
